uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - Buffered 8N1 UART transmitter with a 2**FIFO_AW-entry byte FIFO
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int BAUD_DIV = CLK_FREQ / BAUD,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               rs232_tx,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(BAUD_DIV);
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CW-1:0]    BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [7:0]           mem_q [DEPTH];

    logic push, pop, nonempty, bit_end;

    assign tx_ready   = (count_q != FULL_CNT);
    assign nonempty   = (count_q != '0);
    assign push       = tx_valid && tx_ready;
    assign bit_end    = (baud_q == BAUD_LAST);
    assign rs232_tx   = tx_q;
    assign fifo_count = count_q;
    assign tx_busy    = (state_q != IDLE) || nonempty;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        baud_d    = (state_q == IDLE || bit_end) ? '0 : baud_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q != 3'd7) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Chaining straight into the next start bit keeps queued frames gap-free
                if (bit_end) begin
                    if (nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers and count alone
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - Randomized self-checking bench for uart_tx_fifo against a frame-level model
module tb_uart_tx_fifo;

    localparam int D     = 10;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       rs232_tx;
    logic       tx_busy;
    logic [4:0] fifo_count;

    uart_tx_fifo #(.BAUD_DIV(D), .FIFO_AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rs232_tx   (rs232_tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the remaining clocks of the frame on the line
    logic [7:0] q[$];
    logic [7:0] sent_q[$];
    int         m_left = 0;
    logic [9:0] m_frame = 10'h3ff;
    bit         m_acc = 1'b0;
    int         rst_events = 0;

    always @(posedge clk or negedge rst_n) begin
        bit m_pop, m_push;
        logic [7:0] b;
        if (!rst_n) begin
            q.delete();
            sent_q.delete();
            m_left = 0;
            m_acc  = 1'b0;
            rst_events++;
        end else begin
            m_pop  = (q.size() != 0) && (m_left <= 1);
            m_push = tx_valid && (q.size() < DEPTH);
            m_acc  = m_push;
            if (m_left > 0) m_left--;
            if (m_pop) begin
                b       = q.pop_front();
                m_frame = {1'b1, b, 1'b0};
                m_left  = 10 * D;
                sent_q.push_back(b);
            end
            if (m_push) q.push_back(tx_data);
        end
    end

    function automatic logic exp_line();
        if (m_left == 0) return 1'b1;
        return m_frame[(10 * D - m_left) / D];
    endfunction

    always @(negedge clk) begin
        check_eq("line",  rs232_tx,   exp_line());
        check_eq("count", fifo_count, q.size());
        check_eq("ready", tx_ready,   q.size() < DEPTH);
        check_eq("busy",  tx_busy,    (m_left != 0) || (q.size() != 0));
    end

    // Independent line receiver sampling at mid-bit
    initial begin
        int snap;
        logic [7:0] rb;
        logic st, sp;
        forever begin
            @(negedge clk);
            if (rst_n && rs232_tx === 1'b0) begin
                snap = rst_events;
                repeat (D / 2) @(negedge clk);
                st = rs232_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    rb[i] = rs232_tx;
                end
                repeat (D) @(negedge clk);
                sp = rs232_tx;
                if (snap == rst_events) begin
                    check_eq("rx_start", st, 1'b0);
                    check_eq("rx_stop",  sp, 1'b1);
                    if (sent_q.size() == 0) check_eq("rx_extra", sent_q.size(), 1);
                    else                    check_eq("rx_byte", rb, sent_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && tx_busy; c++) @(negedge clk);
        check_eq("drain_busy", tx_busy, 1'b0);
        repeat (2 * D) @(negedge clk);
    endtask

    initial begin
        int d;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (20000) @(negedge clk);
        check_eq("idle_line", rs232_tx, 1'b1);
        check_eq("idle_busy", tx_busy, 1'b0);

        send(8'hA5);
        drain(20 * D);

        send(8'h00);
        send(8'hFF);
        send(8'h55);
        drain(40 * D);

        send(8'h11);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) send(8'($urandom));
        check_eq("full_count", fifo_count, 16);
        check_eq("full_ready", tx_ready, 1'b0);
        drain(200 * D);

        send(8'h3C);
        for (int i = 0; i < 4; i++) send(8'($urandom));
        repeat (4 * D + D / 2 - 4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_line",  rs232_tx,   1'b1);
        check_eq("rst_count", fifo_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20 * D) @(negedge clk);
        send(8'h81);
        drain(20 * D);

        for (int c = 0; c < 600; c++) begin
            tx_valid = ($urandom_range(0, 7) == 0);
            tx_data  = 8'($urandom);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        drain(200 * D);

        d = 0;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        for (int c = 0; c < 260 * 10 * D && d < 256; c++) begin
            @(negedge clk);
            if (m_acc) begin
                d++;
                tx_data = 8'(d);
            end
        end
        tx_valid = 1'b0;
        check_eq("inc_accepted", d, 256);
        drain(200 * D);

        check_eq("rx_pending", sent_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
